// File: rtl/exu_wb_unit_pkg.sv
// Shared types for the EXU write-back unit: default widths and the buffered result record.
package exu_wb_unit_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NR_REGS_DEF = 32;
  localparam int REG_IDX_W   = $clog2(NR_REGS_DEF);

  typedef struct packed {
    logic [XLEN_DEF-1:0]  pc;
    logic [XLEN_DEF-1:0]  pc_next;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN_DEF-1:0]  data;
    logic                 rf_wen;
  } wb_result_t;

endpackage

// File: rtl/exu_wb_unit_if.sv
// EXU result handshake: the EXU is the master, the write-back unit is the slave.
interface exu_wb_unit_if;
  import exu_wb_unit_pkg::*;

  logic                 exu_valid;
  logic                 exu_ready;
  logic [XLEN_DEF-1:0]  exu_pc;
  logic [XLEN_DEF-1:0]  exu_pc_next;
  logic [REG_IDX_W-1:0] exu_rd;
  logic [XLEN_DEF-1:0]  exu_data;
  logic                 exu_rf_wen;

  modport master (
    output exu_valid,
    output exu_pc,
    output exu_pc_next,
    output exu_rd,
    output exu_data,
    output exu_rf_wen,
    input  exu_ready
  );

  modport slave (
    input  exu_valid,
    input  exu_pc,
    input  exu_pc_next,
    input  exu_rd,
    input  exu_data,
    input  exu_rf_wen,
    output exu_ready
  );

endinterface

// File: rtl/exu_wb_unit_wb_result_fifo.sv
// Result FIFO between the EXU and register write-back; every slot is visible for hazard matching.
module wb_result_fifo
  import exu_wb_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  wb_result_t       wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o,
  output logic [PTR_W-1:0] head_idx_o,
  output wb_result_t       entries_o [DEPTH],
  output logic [DEPTH-1:0] entry_vld_o
);

  wb_result_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && (count_q != '0);
  assign count_o    = count_q;
  assign head_idx_o = rptr_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PTR_W'(1);
    if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i]   = mem_q[i];
      entry_vld_o[i] = (CNT_W'(PTR_W'(i) - rptr_q) < count_q);
    end
  end

endmodule

// File: rtl/exu_wb_unit.sv
// Write-back end of the EXU: buffers results, retires one per cycle into the register file,
// emits a commit record and serves two read ports with pending-write flags.
module exu_wb_unit
  import exu_wb_unit_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEF,
  parameter  int NR_REGS = NR_REGS_DEF,
  parameter  int DEPTH   = 2,
  localparam int RIDX_W  = $clog2(NR_REGS),
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  exu_wb_unit_if.slave      exu,
  input  logic              wb_stall,
  input  logic [RIDX_W-1:0] raddr1,
  input  logic [RIDX_W-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  output logic              busy1,
  output logic              busy2,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic [XLEN-1:0]   commit_pc_next,
  output logic [RIDX_W-1:0] commit_rd,
  output logic [XLEN-1:0]   commit_data,
  output logic              commit_wen,
  output logic [63:0]       instret
);

  wb_result_t       push_rec;
  wb_result_t       head;
  wb_result_t       fifo_entries [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [PTR_W-1:0] fifo_head_idx;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             push, pop, rf_we;

  logic [XLEN-1:0]  rf_q [NR_REGS];
  logic             commit_valid_q;
  wb_result_t       commit_rec_q;
  logic             commit_wen_q;
  logic [63:0]      instret_q, instret_d;

  // Ready looks only at occupancy so a full FIFO refuses a push even on a popping edge.
  assign exu.exu_ready = !fifo_full && !rst;
  assign push          = exu.exu_valid && exu.exu_ready;
  assign pop           = (fifo_count != '0) && !wb_stall;

  assign push_rec = '{pc:      exu.exu_pc,
                      pc_next: exu.exu_pc_next,
                      rd:      exu.exu_rd,
                      data:    exu.exu_data,
                      rf_wen:  exu.exu_rf_wen};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .wdata_i     (push_rec),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .count_o     (fifo_count),
    .head_idx_o  (fifo_head_idx),
    .entries_o   (fifo_entries),
    .entry_vld_o (fifo_vld)
  );

  assign head      = fifo_entries[fifo_head_idx];
  assign rf_we     = pop && head.rf_wen && (head.rd != '0);
  assign instret_d = instret_q + 64'(pop);

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[head.rd] <= head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid_q <= 1'b0;
      commit_rec_q   <= '0;
      commit_wen_q   <= 1'b0;
      instret_q      <= '0;
    end else begin
      commit_valid_q <= pop;
      instret_q      <= instret_d;
      if (pop) begin
        commit_rec_q <= head;
        commit_wen_q <= head.rf_wen && (head.rd != '0);
      end
    end
  end

  // No forwarding from the FIFO; callers use the busy flags to stall instead.
  assign rdata1 = (raddr1 == '0) ? '0 : rf_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : rf_q[raddr2];

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && fifo_entries[i].rf_wen) begin
        if ((fifo_entries[i].rd == raddr1) && (raddr1 != '0)) busy1 = 1'b1;
        if ((fifo_entries[i].rd == raddr2) && (raddr2 != '0)) busy2 = 1'b1;
      end
    end
  end

  assign commit_valid   = commit_valid_q;
  assign commit_pc      = commit_rec_q.pc;
  assign commit_pc_next = commit_rec_q.pc_next;
  assign commit_rd      = commit_rec_q.rd;
  assign commit_data    = commit_rec_q.data;
  assign commit_wen     = commit_wen_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_exu_wb_unit.sv
// Directed bench for exu_wb_unit: a table of single-result pushes plus hand sequences.
module tb_exu_wb_unit;
  import exu_wb_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stall;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2;
  logic        commit_valid;
  logic [31:0] commit_pc, commit_pc_next, commit_data;
  logic [4:0]  commit_rd;
  logic        commit_wen;
  logic [63:0] instret;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_instret = 64'd0;

  always #5 clk = ~clk;

  exu_wb_unit_if exu_if ();

  exu_wb_unit dut (
    .clk            (clk),
    .rst            (rst),
    .exu            (exu_if),
    .wb_stall       (wb_stall),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .busy1          (busy1),
    .busy2          (busy2),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .commit_pc_next (commit_pc_next),
    .commit_rd      (commit_rd),
    .commit_data    (commit_data),
    .commit_wen     (commit_wen),
    .instret        (instret)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
    logic [31:0] pc;
    logic        exp_busy;
    logic        exp_cwen;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] data,
                       input logic wen, input logic [31:0] pc);
    exu_if.exu_valid   = v;
    exu_if.exu_rd      = rd;
    exu_if.exu_data    = data;
    exu_if.exu_rf_wen  = wen;
    exu_if.exu_pc      = pc;
    exu_if.exu_pc_next = pc + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{rd: 5'd1,  data: 32'h0000_0011, wen: 1'b1, pc: 32'h100, exp_busy: 1'b1, exp_cwen: 1'b1, exp_rdata: 32'h0000_0011};
    vecs[1] = '{rd: 5'd2,  data: 32'h0000_0022, wen: 1'b1, pc: 32'h104, exp_busy: 1'b1, exp_cwen: 1'b1, exp_rdata: 32'h0000_0022};
    vecs[2] = '{rd: 5'd0,  data: 32'hDEAD_BEEF, wen: 1'b1, pc: 32'h108, exp_busy: 1'b0, exp_cwen: 1'b0, exp_rdata: 32'h0};
    vecs[3] = '{rd: 5'd7,  data: 32'h0000_0077, wen: 1'b1, pc: 32'h10C, exp_busy: 1'b1, exp_cwen: 1'b1, exp_rdata: 32'h0000_0077};
    vecs[4] = '{rd: 5'd7,  data: 32'h0000_1234, wen: 1'b0, pc: 32'h110, exp_busy: 1'b0, exp_cwen: 1'b0, exp_rdata: 32'h0000_0077};
    vecs[5] = '{rd: 5'd31, data: 32'hFFFF_FFFF, wen: 1'b1, pc: 32'h114, exp_busy: 1'b1, exp_cwen: 1'b1, exp_rdata: 32'hFFFF_FFFF};

    rst      = 1'b1;
    wb_stall = 1'b0;
    raddr1   = 5'd5;
    raddr2   = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);

    // Reset state
    #2;
    chk("reset_ready", 64'(exu_if.exu_ready), 64'd0);
    chk("reset_commit_valid", 64'(commit_valid), 64'd0);
    chk("reset_instret", instret, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 64'(exu_if.exu_ready), 64'd1);
    chk("post_reset_rdata1_r5", 64'(rdata1), 64'd0);
    chk("post_reset_busy1", 64'(busy1), 64'd0);

    // Table: one result per vector, pushed then retired on the next edge
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].rd, vecs[i].data, vecs[i].wen, vecs[i].pc);
      raddr1 = vecs[i].rd;
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      #1;
      chk($sformatf("v%0d_busy_buffered", i), 64'(busy1), 64'(vecs[i].exp_busy));
      chk($sformatf("v%0d_commit_idle", i), 64'(commit_valid), 64'd0);
      tick();
      exp_instret++;
      chk($sformatf("v%0d_commit_valid", i), 64'(commit_valid), 64'd1);
      chk($sformatf("v%0d_commit_pc", i), 64'(commit_pc), 64'(vecs[i].pc));
      chk($sformatf("v%0d_commit_pc_next", i), 64'(commit_pc_next), 64'(vecs[i].pc + 32'd4));
      chk($sformatf("v%0d_commit_rd", i), 64'(commit_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_commit_data", i), 64'(commit_data), 64'(vecs[i].data));
      chk($sformatf("v%0d_commit_wen", i), 64'(commit_wen), 64'(vecs[i].exp_cwen));
      chk($sformatf("v%0d_rdata1", i), 64'(rdata1), 64'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_busy_after", i), 64'(busy1), 64'd0);
      chk($sformatf("v%0d_instret", i), instret, exp_instret);
    end

    // Back-to-back pushes: simultaneous push/pop keeps the stream flowing
    drive(1'b1, 5'd3, 32'h33, 1'b1, 32'h200);
    tick();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 32'h204);
    #1;
    chk("b2b_ready_second", 64'(exu_if.exu_ready), 64'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    raddr1 = 5'd3;
    raddr2 = 5'd4;
    #1;
    chk("b2b_commit1_valid", 64'(commit_valid), 64'd1);
    chk("b2b_commit1_pc", 64'(commit_pc), 64'h200);
    chk("b2b_rdata1_r3", 64'(rdata1), 64'h33);
    chk("b2b_busy2_r4", 64'(busy2), 64'd1);
    tick();
    chk("b2b_commit2_valid", 64'(commit_valid), 64'd1);
    chk("b2b_commit2_pc", 64'(commit_pc), 64'h204);
    chk("b2b_rdata2_r4", 64'(rdata2), 64'h44);
    chk("b2b_busy2_cleared", 64'(busy2), 64'd0);
    tick();
    exp_instret += 2;
    chk("b2b_commit_drop", 64'(commit_valid), 64'd0);
    chk("b2b_instret", instret, exp_instret);

    // Stall fills the FIFO; release with the third result held at a full FIFO
    wb_stall = 1'b1;
    drive(1'b1, 5'd5, 32'h55, 1'b1, 32'h300);
    tick();
    drive(1'b1, 5'd6, 32'h66, 1'b1, 32'h304);
    tick();
    drive(1'b1, 5'd8, 32'h88, 1'b1, 32'h308);
    raddr1 = 5'd5;
    raddr2 = 5'd6;
    #1;
    chk("stall_full_ready", 64'(exu_if.exu_ready), 64'd0);
    chk("stall_busy1_r5", 64'(busy1), 64'd1);
    chk("stall_busy2_r6", 64'(busy2), 64'd1);
    chk("stall_commit_valid", 64'(commit_valid), 64'd0);
    tick();
    chk("stall_hold_ready", 64'(exu_if.exu_ready), 64'd0);
    chk("stall_hold_instret", instret, exp_instret);
    wb_stall = 1'b0;
    #1;
    chk("full_popping_ready", 64'(exu_if.exu_ready), 64'd0);
    tick();
    chk("rel_commit_a_valid", 64'(commit_valid), 64'd1);
    chk("rel_commit_a_pc", 64'(commit_pc), 64'h300);
    chk("rel_ready_after_pop", 64'(exu_if.exu_ready), 64'd1);
    chk("rel_busy1_r5_clear", 64'(busy1), 64'd0);
    chk("rel_busy2_r6", 64'(busy2), 64'd1);
    chk("rel_rdata1_r5", 64'(rdata1), 64'h55);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    raddr1 = 5'd8;
    #1;
    chk("rel_commit_b_pc", 64'(commit_pc), 64'h304);
    chk("rel_commit_b_valid", 64'(commit_valid), 64'd1);
    chk("rel_busy1_r8", 64'(busy1), 64'd1);
    tick();
    chk("rel_commit_c_valid", 64'(commit_valid), 64'd1);
    chk("rel_commit_c_pc", 64'(commit_pc), 64'h308);
    chk("rel_commit_c_rd", 64'(commit_rd), 64'd8);
    chk("rel_rdata1_r8", 64'(rdata1), 64'h88);
    tick();
    exp_instret += 3;
    chk("rel_no_duplicate", 64'(commit_valid), 64'd0);
    chk("rel_instret", instret, exp_instret);

    // Reset with two entries buffered
    wb_stall = 1'b1;
    drive(1'b1, 5'd9, 32'h99, 1'b1, 32'h400);
    tick();
    drive(1'b1, 5'd10, 32'hAA, 1'b1, 32'h404);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    raddr1 = 5'd9;
    raddr2 = 5'd10;
    #1;
    chk("pre_rst_busy1_r9", 64'(busy1), 64'd1);
    raddr1 = 5'd5;
    #1;
    chk("pre_rst_rdata1_r5", 64'(rdata1), 64'h55);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(exu_if.exu_ready), 64'd0);
    chk("mid_rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("mid_rst_instret", instret, 64'd0);
    chk("mid_rst_rdata1_r5", 64'(rdata1), 64'd0);
    chk("mid_rst_busy2_r10", 64'(busy2), 64'd0);
    tick();
    tick();
    wb_stall = 1'b0;
    rst      = 1'b0;
    raddr1   = 5'd9;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post_rst_c%0d_commit_valid", c), 64'(commit_valid), 64'd0);
      chk($sformatf("post_rst_c%0d_instret", c), instret, 64'd0);
      chk($sformatf("post_rst_c%0d_ready", c), 64'(exu_if.exu_ready), 64'd1);
    end
    chk("post_rst_rdata1_r9", 64'(rdata1), 64'd0);
    chk("post_rst_busy1_r9", 64'(busy1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_wb_unit.md
Name: exu_wb_unit

Overview:
- Write-back end of the EXU result interface. Accepts per-instruction results (rd, data, rf_wen, pc, pc_next) from the EXU over a valid/ready handshake and buffers them in a small FIFO.
- Retires one entry per cycle into the architectural register file and emits a one-cycle commit record.
- Serves two combinational register read ports to the decode stage, plus per-port pending-write (busy) flags for hazard detection.

Parameters:
- XLEN, 32, data and pc width.
- NR_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- DEPTH, 2, result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- exu_valid  in  1  EXU result present.
- exu_ready  out  1  unit can accept a result this cycle.
- exu_pc  in  XLEN  pc of the instruction.
- exu_pc_next  in  XLEN  next pc computed by the EXU.
- exu_rd  in  log2(NR_REGS)  destination register index.
- exu_data  in  XLEN  result value.
- exu_rf_wen  in  1  result writes rd.
- wb_stall  in  1  inhibit retirement this cycle (debug/difftest hold).
- raddr1, raddr2  in  log2(NR_REGS)  read addresses.
- rdata1, rdata2  out  XLEN  register contents, combinational.
- busy1, busy2  out  1  a buffered, not-yet-retired entry will write raddrN.
- commit_valid  out  1  one-cycle retirement pulse.
- commit_pc, commit_pc_next  out  XLEN  pc and pc_next of the retired entry.
- commit_rd  out  log2(NR_REGS)  rd of the retired entry.
- commit_data  out  XLEN  data of the retired entry.
- commit_wen  out  1  the retired entry wrote a nonzero register.
- instret  out  64  retired-instruction counter.

Behaviour:
- Reset (asynchronous, effective immediately):
  - FIFO empties; all buffered entries are discarded, including during reset mid-operation.
  - All registers clear to 0.
  - commit_valid=0; commit_pc, commit_pc_next, commit_rd, commit_data and commit_wen all 0.
  - instret=0.
  - exu_ready=0 while rst is high; exu_ready=1 in the first cycle after release.
- Handshake:
  - Push occurs when exu_valid && exu_ready at the clock edge.
  - exu_ready = !full && !rst. It depends only on the occupancy register, never on the same-cycle pop. A full FIFO that is popping still refuses the push that cycle.
  - A producer that holds exu_valid while exu_ready=0 keeps its inputs stable; the unit stores nothing.
- Retire:
  - The head entry retires at an edge when count>0 && !wb_stall.
  - The register file write happens at that edge when rf_wen && rd!=0; an rd==0 write is discarded silently.
  - commit_* registers load the head at that edge. commit_valid=1 for exactly the following cycle unless another retire follows.
  - instret increments by 1 per retire and wraps modulo 2^64.
- Latency and throughput:
  - A result pushed at edge N retires at edge N+1 at the earliest; its register value is readable after edge N+1.
  - Sustained throughput is 1 result per cycle with no stall; count stays at 1.
- Simultaneous push and pop: the pointers advance together and count is unchanged.
  - Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH. full = (count==DEPTH).
- Read ports:
  - rdataN = regfile[raddrN]; address 0 always reads 0.
  - There is no forwarding from the FIFO: a same-edge write becomes visible the cycle after.
  - busyN = 1 iff any valid FIFO entry has rf_wen=1 and rd==raddrN!=0. The head is included in the check while stalled or while about to retire.
- wb_stall held high: the FIFO fills to DEPTH, then exu_ready=0. Release resumes retirement in FIFO order, one entry per cycle.

Decomposition:
- Shared package holds:
  - XLEN and NR_REGS defaults.
  - Reg-index width constant.
  - The result record typedef (pc, pc_next, rd, data, rf_wen), reused by the EXU output port.
- One sub-module, wb_result_fifo:
  - Parameterised DEPTH; push/pop/full/empty/count.
  - Exposes all entries so the busy match can be computed.
- The register file and commit logic stay in the top level.

Test Plan:
- Reset check: assert rst mid-stream with 2 entries buffered -> exu_ready=0 and commit_valid=0 immediately; after release, instret=0, rdata1(raddr1=5)=0, and the buffered entries are never committed.
- Back-to-back traffic: push rd=1 data=0x11, then rd=2 data=0x22 on consecutive cycles -> commit_valid high on 2 consecutive cycles with pc order preserved; rdata1(1)=0x11 and rdata2(2)=0x22 from the cycle after each retire; instret=2.
- x0 write: push rd=0 data=0xDEADBEEF rf_wen=1 -> commit_valid=1, commit_wen=0, rdata1(0)=0.
- Stall and full: hold wb_stall, push 3 results -> first 2 accepted, exu_ready=0 on the third; busy1=1 for raddr1=a buffered rd. Release the stall -> the 3rd is accepted and all retire in order.
- rf_wen=0 entry with rd=7: busy1(7)=0 and register 7 is unchanged after retire, but instret still increments.
- Full with same-edge pop: FIFO full and wb_stall deasserted with exu_valid held -> no push that edge; the push happens the next edge, and count never exceeds DEPTH.
